// File: rtl/program_loader_if.sv
// Host stream and memory-load bundle between the program loader and its neighbours.
// The master side feeds the stream; the slave side is the loader itself.
interface program_loader_if #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
);
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     loading;
    logic                     im_cen_load;
    logic                     im_wen_load;
    logic                     im_oen_load;
    logic [ADDRESS_WIDTH-1:0] im_addr_load;
    logic [DATA_WIDTH-1:0]    im_datain_load;
    logic                     dm_cen_load;
    logic                     dm_wen_load;
    logic                     dm_oen_load;
    logic [ADDRESS_WIDTH-1:0] dm_addr_load;
    logic [DATA_WIDTH-1:0]    dm_datain_load;
    logic                     proc_rst_n;
    logic [11:0]              words_loaded;
    logic                     busy;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, loading,
        input  im_cen_load, im_wen_load, im_oen_load, im_addr_load, im_datain_load,
        input  dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load,
        input  proc_rst_n, words_loaded, busy
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, loading,
        output im_cen_load, im_wen_load, im_oen_load, im_addr_load, im_datain_load,
        output dm_cen_load, dm_wen_load, dm_oen_load, dm_addr_load, dm_datain_load,
        output proc_rst_n, words_loaded, busy
    );
endinterface

// File: rtl/program_loader.sv
// Decodes a host word stream into IM/DM load writes, then releases the
// processor core from reset after a short flush window.
module program_loader #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);
    typedef enum logic [1:0] {S_HDR, S_DATA, S_RELEASE, S_RUN} state_t;

    localparam logic [3:0]               FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE_WORD   = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic                     accept;
    logic                     target_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] remaining_q;
    logic [3:0]               flush_cnt_q;
    logic                     in_ready_q, loading_q, busy_q, proc_rst_n_q;
    logic [11:0]              words_loaded_q;
    logic                     im_cen_q, im_wen_q, dm_cen_q, dm_wen_q;
    logic [ADDRESS_WIDTH-1:0] im_addr_q, dm_addr_q;
    logic [DATA_WIDTH-1:0]    im_data_q, dm_data_q;
    logic                     unused_in_data;

    // Header bits outside target/address/count carry no meaning.
    assign unused_in_data = ^bus.in_data;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HDR: begin
                if (accept) begin
                    state_d = (bus.in_data[ADDRESS_WIDTH-1:0] == '0) ? S_RELEASE : S_DATA;
                end
            end
            S_DATA: begin
                if (accept && remaining_q == ONE_WORD) begin
                    state_d = S_HDR;
                end
            end
            S_RELEASE: state_d = S_RUN;
            S_RUN: begin
                if (bus.start) begin
                    state_d = S_HDR;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_HDR;
            in_ready_q     <= 1'b0;
            loading_q      <= 1'b1;
            busy_q         <= 1'b1;
            proc_rst_n_q   <= 1'b0;
            words_loaded_q <= '0;
            target_q       <= 1'b0;
            addr_q         <= '0;
            remaining_q    <= '0;
            flush_cnt_q    <= '0;
            im_cen_q       <= 1'b1;
            im_wen_q       <= 1'b1;
            dm_cen_q       <= 1'b1;
            dm_wen_q       <= 1'b1;
            im_addr_q      <= '0;
            dm_addr_q      <= '0;
            im_data_q      <= '0;
            dm_data_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == S_HDR) || (state_d == S_DATA);
            loading_q  <= (state_d != S_RUN);
            busy_q     <= (state_d != S_RUN);
            // Strobes are single-cycle pulses; only an accept in DATA re-arms them.
            im_cen_q   <= 1'b1;
            im_wen_q   <= 1'b1;
            dm_cen_q   <= 1'b1;
            dm_wen_q   <= 1'b1;
            case (state_q)
                S_HDR: begin
                    if (accept) begin
                        target_q    <= bus.in_data[DATA_WIDTH-1];
                        addr_q      <= bus.in_data[16+ADDRESS_WIDTH-1:16];
                        remaining_q <= bus.in_data[ADDRESS_WIDTH-1:0];
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (target_q) begin
                            dm_cen_q  <= 1'b0;
                            dm_wen_q  <= 1'b0;
                            dm_addr_q <= addr_q;
                            dm_data_q <= bus.in_data;
                        end else begin
                            im_cen_q  <= 1'b0;
                            im_wen_q  <= 1'b0;
                            im_addr_q <= addr_q;
                            im_data_q <= bus.in_data;
                        end
                        addr_q      <= addr_q + ONE_WORD;
                        remaining_q <= remaining_q - ONE_WORD;
                        if (words_loaded_q != '1) begin
                            words_loaded_q <= words_loaded_q + 12'd1;
                        end
                    end
                end
                S_RELEASE: flush_cnt_q <= '0;
                S_RUN: begin
                    if (bus.start) begin
                        proc_rst_n_q   <= 1'b0;
                        words_loaded_q <= '0;
                        target_q       <= 1'b0;
                        addr_q         <= '0;
                        remaining_q    <= '0;
                    end else if (flush_cnt_q == FLUSH_LAST) begin
                        proc_rst_n_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.loading        = loading_q;
    assign bus.busy           = busy_q;
    assign bus.proc_rst_n     = proc_rst_n_q;
    assign bus.words_loaded   = words_loaded_q;
    assign bus.im_cen_load    = im_cen_q;
    assign bus.im_wen_load    = im_wen_q;
    assign bus.im_oen_load    = 1'b1;
    assign bus.im_addr_load   = im_addr_q;
    assign bus.im_datain_load = im_data_q;
    assign bus.dm_cen_load    = dm_cen_q;
    assign bus.dm_wen_load    = dm_wen_q;
    assign bus.dm_oen_load    = 1'b1;
    assign bus.dm_addr_load   = dm_addr_q;
    assign bus.dm_datain_load = dm_data_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: randomized load sessions checked against a
// header-decoding write model, plus release/flush/restart/reset scenarios.
module tb_program_loader;
    localparam int AW = 11;
    localparam int DW = 32;

    typedef struct packed {
        logic        tgt;
        logic [10:0] addr;
        logic [31:0] data;
        logic        wen;
        logic        oen;
        logic [31:0] c;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          both_cnt = 0;
    int          exp_wl = 0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];

    program_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    program_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write seen on the load ports, tagged with its cycle.
    always @(negedge clk) begin
        if (bus.im_cen_load == 1'b0 && bus.dm_cen_load == 1'b0) both_cnt++;
        if (bus.im_cen_load == 1'b0)
            obs_q.push_back('{tgt: 1'b0, addr: bus.im_addr_load, data: bus.im_datain_load,
                              wen: bus.im_wen_load, oen: bus.im_oen_load, c: cyc});
        if (bus.dm_cen_load == 1'b0)
            obs_q.push_back('{tgt: 1'b1, addr: bus.dm_addr_load, data: bus.dm_datain_load,
                              wen: bus.dm_wen_load, oen: bus.dm_oen_load, c: cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Present one word from a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] w, output bit ok, output int unsigned acc_cyc);
        ok = 1'b0;
        acc_cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int n = 0; n < 40; n++) begin
            if (bus.in_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Reference model: header decode -> expected writes at consecutive wrapped addresses.
    task automatic load_session(input logic [31:0] hdr, input int max_gap, output bit ok);
        bit          o;
        int unsigned c;
        logic [31:0] w;
        logic [10:0] a;
        int          n;
        send_word(hdr, o, c);
        ok = o;
        n  = int'(hdr[10:0]);
        a  = hdr[26:16];
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            w = $urandom;
            send_word(w, o, c);
            ok = ok & o;
            exp_q.push_back('{tgt: hdr[31], addr: a, data: w, wen: 1'b0, oen: 1'b1, c: c});
            a = a + 11'd1;
            if (exp_wl < 4095) exp_wl++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.loading !== 1'b1) begin failures++; $display("FAIL reset_loading got=%b want=1", bus.loading); end
        checks++; if (bus.proc_rst_n !== 1'b0) begin failures++; $display("FAIL reset_proc_rst_n got=%b want=0", bus.proc_rst_n); end
        checks++; if (bus.words_loaded !== 12'd0) begin failures++; $display("FAIL reset_words got=%0d want=0", bus.words_loaded); end
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_busy_ready got=%b%b want=10", bus.busy, bus.in_ready); end
        checks++;
        if ({bus.im_cen_load, bus.im_wen_load, bus.im_oen_load, bus.dm_cen_load, bus.dm_wen_load, bus.dm_oen_load} !== 6'b111111) begin
            failures++; $display("FAIL reset_strobes got=%b%b%b%b%b%b want=111111", bus.im_cen_load, bus.im_wen_load, bus.im_oen_load, bus.dm_cen_load, bus.dm_wen_load, bus.dm_oen_load);
        end
        checks++;
        if ({bus.im_addr_load, bus.dm_addr_load, bus.im_datain_load, bus.dm_datain_load} !== '0) begin
            failures++; $display("FAIL reset_addr_data got=%h/%h/%h/%h want=0", bus.im_addr_load, bus.dm_addr_load, bus.im_datain_load, bus.dm_datain_load);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b want=1", bus.in_ready); end
        exp_wl = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_im_load();
        bit ok;
        load_session(32'h0000_0003, 0, ok);
        repeat (2) @(negedge clk);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL im_load_handshake got=%b want=1", ok); end
        checks++;
        if (exp_q.size() == 3 && exp_q[2].c - exp_q[0].c != 2) begin
            failures++; $display("FAIL im_load_back_to_back got_span=%0d want=2", exp_q[2].c - exp_q[0].c);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL im_load_write_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL im_load_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (bus.words_loaded !== 12'(exp_wl)) begin failures++; $display("FAIL im_load_words got=%0d want=%0d", bus.words_loaded, exp_wl); end
        checks++; if ({bus.in_ready, bus.busy, bus.loading} !== 3'b111) begin failures++; $display("FAIL im_load_back_in_hdr got=%b%b%b want=111", bus.in_ready, bus.busy, bus.loading); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_dm_gap();
        bit o, ok;
        int unsigned c;
        send_word(32'h8005_0002, ok, c);
        send_word(32'hDEAD_BEEF, o, c);
        ok = ok & o;
        exp_q.push_back('{tgt: 1'b1, addr: 11'd5, data: 32'hDEAD_BEEF, wen: 1'b0, oen: 1'b1, c: c});
        @(negedge clk);
        checks++;
        if ({bus.im_cen_load, bus.dm_cen_load, bus.dm_wen_load} !== 3'b111) begin
            failures++; $display("FAIL dm_gap_idle_strobes got=%b%b%b want=111", bus.im_cen_load, bus.dm_cen_load, bus.dm_wen_load);
        end
        send_word(32'h1234_5678, o, c);
        ok = ok & o;
        exp_q.push_back('{tgt: 1'b1, addr: 11'd6, data: 32'h1234_5678, wen: 1'b0, oen: 1'b1, c: c});
        exp_wl = exp_wl + 2;
        repeat (2) @(negedge clk);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL dm_gap_handshake got=%b want=1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL dm_gap_write_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL dm_gap_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (bus.words_loaded !== 12'(exp_wl)) begin failures++; $display("FAIL dm_gap_words got=%0d want=%0d", bus.words_loaded, exp_wl); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_wrap_and_random();
        bit ok, o;
        logic [31:0] hdr;
        load_session(32'h07FF_0002, 0, ok);
        for (int s = 0; s < 6; s++) begin
            hdr = $urandom;
            hdr[10:0] = 11'($urandom_range(7, 1));
            load_session(hdr, 2, o);
            ok = ok & o;
        end
        repeat (2) @(negedge clk);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL random_handshake got=%b want=1", ok); end
        checks++;
        if (exp_q.size() >= 2 && (obs_q.size() < 2 || obs_q[0].addr !== 11'd2047 || obs_q[1].addr !== 11'd0)) begin
            failures++; $display("FAIL wrap_addr got=%0d,%0d want=2047,0", obs_q.size() > 0 ? obs_q[0].addr : 11'd0, obs_q.size() > 1 ? obs_q[1].addr : 11'd0);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL random_write_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (bus.words_loaded !== 12'(exp_wl)) begin failures++; $display("FAIL random_words got=%0d want=%0d", bus.words_loaded, exp_wl); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_terminator();
        bit ok;
        int unsigned c;
        send_word(32'h0000_0000, ok, c);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL term_handshake got=%b want=1", ok); end
        checks++;
        if ({bus.in_ready, bus.loading, bus.busy, bus.proc_rst_n} !== 4'b0110) begin
            failures++; $display("FAIL term_release got=%b%b%b%b want=0110", bus.in_ready, bus.loading, bus.busy, bus.proc_rst_n);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0004;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.loading, bus.busy, bus.proc_rst_n} !== 4'b0000) begin
            failures++; $display("FAIL term_run1 got=%b%b%b%b want=0000", bus.in_ready, bus.loading, bus.busy, bus.proc_rst_n);
        end
        @(negedge clk);
        checks++; if (bus.proc_rst_n !== 1'b0) begin failures++; $display("FAIL term_flush2 got=%b want=0", bus.proc_rst_n); end
        @(negedge clk);
        checks++; if (bus.proc_rst_n !== 1'b1) begin failures++; $display("FAIL term_flush_end got=%b want=1", bus.proc_rst_n); end
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (obs_q.size() != 0 || bus.loading !== 1'b0 || bus.words_loaded !== 12'(exp_wl)) begin
            failures++; $display("FAIL term_run_ignores_valid got_writes=%0d loading=%b words=%0d want_writes=0 loading=0 words=%0d", obs_q.size(), bus.loading, bus.words_loaded, exp_wl);
        end
    endtask

    task automatic test_restart();
        bit ok;
        logic [31:0] hdr;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.loading, bus.proc_rst_n, bus.busy, bus.in_ready} !== 4'b1011 || bus.words_loaded !== 12'd0) begin
            failures++; $display("FAIL restart_state got=%b%b%b%b words=%0d want=1011 words=0", bus.loading, bus.proc_rst_n, bus.busy, bus.in_ready, bus.words_loaded);
        end
        exp_wl = 0;
        hdr = $urandom;
        hdr[31] = 1'b0;
        hdr[10:0] = 11'($urandom_range(6, 1));
        load_session(hdr, 1, ok);
        repeat (2) @(negedge clk);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL restart_handshake got=%b want=1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL restart_write_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (bus.words_loaded !== 12'(exp_wl) || bus.proc_rst_n !== 1'b0) begin failures++; $display("FAIL restart_words got=%0d prn=%b want=%0d prn=0", bus.words_loaded, bus.proc_rst_n, exp_wl); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        bit ok, o;
        load_session(32'h0000_07FF, 0, ok);
        load_session(32'h8000_07FF, 0, o);
        ok = ok & o;
        load_session(32'h0010_0003, 0, o);
        ok = ok & o;
        repeat (2) @(negedge clk);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sat_handshake got=%b want=1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL sat_write_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL sat_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (bus.words_loaded !== 12'(exp_wl)) begin failures++; $display("FAIL sat_words got=%0d want=%0d", bus.words_loaded, exp_wl); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        bit ok, o;
        int unsigned c;
        logic [31:0] w;
        logic [10:0] a;
        logic [31:0] hdr;
        a = 11'($urandom);
        send_word({5'b0, a, 16'h0004}, ok, c);
        w = $urandom;
        send_word(w, o, c);
        ok = ok & o;
        exp_q.push_back('{tgt: 1'b0, addr: a, data: w, wen: 1'b0, oen: 1'b1, c: c});
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.im_cen_load, bus.dm_cen_load, bus.loading, bus.proc_rst_n, bus.in_ready, bus.busy} !== 6'b111001 || bus.words_loaded !== 12'd0 || bus.im_addr_load !== 11'd0) begin
            failures++; $display("FAIL mid_reset_outputs got=%b%b%b%b%b%b words=%0d addr=%0d want=111001 words=0 addr=0", bus.im_cen_load, bus.dm_cen_load, bus.loading, bus.proc_rst_n, bus.in_ready, bus.busy, bus.words_loaded, bus.im_addr_load);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b want=1", bus.in_ready); end
        exp_wl = 0;
        hdr = $urandom;
        hdr[31] = 1'b1;
        hdr[10:0] = 11'd2;
        load_session(hdr, 1, o);
        ok = ok & o;
        repeat (2) @(negedge clk);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_reset_handshake got=%b want=1", ok); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL mid_reset_write_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_reset_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (bus.words_loaded !== 12'(exp_wl)) begin failures++; $display("FAIL mid_reset_words got=%0d want=%0d", bus.words_loaded, exp_wl); end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_im_load();
        test_dm_gap();
        test_wrap_and_random();
        test_terminator();
        test_restart();
        test_saturation();
        test_mid_reset();
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL exclusive_memories got=%0d want=0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
